// File: rtl/li_fir_arbiter.sv
// Round-robin arbiter that shares one FIR LI shell among NCH requesters and
// routes shell results back to the issuing channel through an in-flight tag FIFO.
module li_fir_arbiter #(
  parameter int NCH      = 4,
  parameter int DW       = 17,
  parameter int TAG_ADDR = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*DW-1:0]   i_data,
  input  logic [NCH-1:0]      i_valid,
  output logic [NCH-1:0]      o_stop,
  output logic [DW-1:0]       s_data,
  output logic                s_valid,
  input  logic                s_stop,
  input  logic [DW-1:0]       r_data,
  input  logic                r_valid,
  output logic                r_stop,
  output logic [NCH*DW-1:0]   c_data,
  output logic [NCH-1:0]      c_valid,
  input  logic [NCH-1:0]      c_stop,
  output logic [TAG_ADDR:0]   o_inflight,
  output logic                o_err
);

  localparam int CW     = $clog2(NCH);
  localparam int TDEPTH = 1 << TAG_ADDR;

  logic [DW-1:0]       in_mem_q  [NCH][2];
  logic [DW-1:0]       in_mem_d  [NCH][2];
  logic [NCH-1:0]      in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [1:0]          in_cnt_q  [NCH];
  logic [1:0]          in_cnt_d  [NCH];

  logic [DW-1:0]       ret_mem_q [NCH][2];
  logic [DW-1:0]       ret_mem_d [NCH][2];
  logic [NCH-1:0]      ret_wp_q, ret_wp_d, ret_rp_q, ret_rp_d;
  logic [1:0]          ret_cnt_q [NCH];
  logic [1:0]          ret_cnt_d [NCH];

  logic [CW-1:0]       tag_mem_q [TDEPTH];
  logic [CW-1:0]       tag_mem_d [TDEPTH];
  logic [TAG_ADDR-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [TAG_ADDR:0]   tag_cnt_q, tag_cnt_d;

  logic [CW-1:0]       rr_q, rr_d;
  logic                s_valid_q, s_valid_d;
  logic [DW-1:0]       s_data_q, s_data_d;
  logic                err_q, err_d;

  logic                issue, any_ne, r_take, drop;
  logic [CW-1:0]       grant, scan_idx, r_ch;
  logic [NCH-1:0]      in_push, in_pop, ret_push, c_pop;

  function automatic logic [1:0] cnt2_next(input logic [1:0] c, input logic push,
                                           input logic pop);
    logic [1:0] n;
    n = c;
    if (push && !pop)      n = c + 2'd1;
    else if (!push && pop) n = c - 2'd1;
    return n;
  endfunction

  // Issue decision uses only registered occupancy, so a same-cycle return
  // never frees a tag slot for the current grant.
  always_comb begin
    any_ne   = 1'b0;
    grant    = rr_q;
    scan_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = CW'((int'(rr_q) + i) % NCH);
      if (!any_ne && in_cnt_q[scan_idx] != 2'd0) begin
        any_ne = 1'b1;
        grant  = scan_idx;
      end
    end
    issue = !s_stop && (tag_cnt_q != (TAG_ADDR+1)'(TDEPTH)) && any_ne;
  end

  always_comb begin
    r_take = r_valid && (tag_cnt_q != '0);
    r_ch   = tag_mem_q[tag_rp_q];
    drop   = r_valid && !r_take;
    for (int k = 0; k < NCH; k++) begin
      c_pop[k]    = (ret_cnt_q[k] != 2'd0) && !c_stop[k];
      ret_push[k] = r_take && (r_ch == CW'(k)) && ((ret_cnt_q[k] != 2'd2) || c_pop[k]);
      if (r_take && (r_ch == CW'(k)) && !ret_push[k]) drop = 1'b1;
      in_pop[k]   = issue && (grant == CW'(k));
      in_push[k]  = i_valid[k] && ((in_cnt_q[k] != 2'd2) || in_pop[k]);
      if (i_valid[k] && !in_push[k]) drop = 1'b1;
    end
  end

  always_comb begin
    in_mem_d  = in_mem_q;
    ret_mem_d = ret_mem_q;
    in_cnt_d  = in_cnt_q;
    ret_cnt_d = ret_cnt_q;
    for (int k = 0; k < NCH; k++) begin
      if (in_push[k])  in_mem_d[k][in_wp_q[k]]   = i_data[k*DW +: DW];
      if (ret_push[k]) ret_mem_d[k][ret_wp_q[k]] = r_data;
      in_cnt_d[k]  = cnt2_next(in_cnt_q[k], in_push[k], in_pop[k]);
      ret_cnt_d[k] = cnt2_next(ret_cnt_q[k], ret_push[k], c_pop[k]);
    end
    in_wp_d  = in_wp_q ^ in_push;
    in_rp_d  = in_rp_q ^ in_pop;
    ret_wp_d = ret_wp_q ^ ret_push;
    ret_rp_d = ret_rp_q ^ c_pop;

    tag_mem_d = tag_mem_q;
    if (issue) tag_mem_d[tag_wp_q] = grant;
    tag_wp_d  = tag_wp_q + TAG_ADDR'(issue);
    tag_rp_d  = tag_rp_q + TAG_ADDR'(r_take);
    tag_cnt_d = tag_cnt_q;
    if (issue && !r_take)      tag_cnt_d = tag_cnt_q + 1'b1;
    else if (!issue && r_take) tag_cnt_d = tag_cnt_q - 1'b1;

    rr_d = rr_q;
    if (issue) rr_d = (grant == CW'(NCH-1)) ? '0 : grant + 1'b1;
    s_valid_d = issue;
    s_data_d  = issue ? in_mem_q[grant][in_rp_q[grant]] : s_data_q;
    err_d     = err_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '{default: 2'd0};
      ret_wp_q  <= '0;
      ret_rp_q  <= '0;
      ret_cnt_q <= '{default: 2'd0};
      tag_wp_q  <= '0;
      tag_rp_q  <= '0;
      tag_cnt_q <= '0;
      rr_q      <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      in_cnt_q  <= in_cnt_d;
      ret_wp_q  <= ret_wp_d;
      ret_rp_q  <= ret_rp_d;
      ret_cnt_q <= ret_cnt_d;
      tag_wp_q  <= tag_wp_d;
      tag_rp_q  <= tag_rp_d;
      tag_cnt_q <= tag_cnt_d;
      rr_q      <= rr_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: every read is qualified by a count.
  always_ff @(posedge clk) begin
    in_mem_q  <= in_mem_d;
    ret_mem_q <= ret_mem_d;
    tag_mem_q <= tag_mem_d;
  end

  always_comb begin
    r_stop = 1'b0;
    c_data = '0;
    for (int k = 0; k < NCH; k++) begin
      o_stop[k]          = (in_cnt_q[k] != 2'd0);
      c_valid[k]         = (ret_cnt_q[k] != 2'd0);
      c_data[k*DW +: DW] = ret_mem_q[k][ret_rp_q[k]];
      if ((ret_cnt_q[k] == 2'd2) || ((ret_cnt_q[k] != 2'd0) && c_stop[k])) r_stop = 1'b1;
    end
  end

  assign s_valid    = s_valid_q;
  assign s_data     = s_data_q;
  assign o_inflight = tag_cnt_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_li_fir_arbiter.sv
// Directed and randomized bench for li_fir_arbiter against a queue-based
// reference model of the arbitration and tag-return rules.
module tb_li_fir_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 17;
  localparam int TA  = 3;
  localparam int TDEPTH = 1 << TA;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*DW-1:0] i_data;
  logic [NCH-1:0]    i_valid;
  logic [NCH-1:0]    o_stop;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_stop;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic              r_stop;
  logic [NCH*DW-1:0] c_data;
  logic [NCH-1:0]    c_valid;
  logic [NCH-1:0]    c_stop;
  logic [TA:0]       o_inflight;
  logic              o_err;

  li_fir_arbiter #(.NCH(NCH), .DW(DW), .TAG_ADDR(TA)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .o_stop(o_stop),
    .s_data(s_data), .s_valid(s_valid), .s_stop(s_stop), .r_data(r_data),
    .r_valid(r_valid), .r_stop(r_stop), .c_data(c_data), .c_valid(c_valid),
    .c_stop(c_stop), .o_inflight(o_inflight), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  logic [DW-1:0] m_in  [NCH][$];
  logic [DW-1:0] m_ret [NCH][$];
  int            m_tag [$];
  int            m_rr;
  bit            m_sv;
  logic [DW-1:0] m_sd;
  bit            m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NCH; k++) begin
      m_in[k].delete();
      m_ret[k].delete();
    end
    m_tag.delete();
    m_rr = 0; m_sv = 0; m_sd = '0; m_err = 0;
  endtask

  function automatic logic [NCH-1:0] exp_stop();
    logic [NCH-1:0] s;
    for (int k = 0; k < NCH; k++) s[k] = (m_in[k].size() != 0);
    return s;
  endfunction

  function automatic bit exp_rstop();
    bit r = 0;
    for (int k = 0; k < NCH; k++)
      if (m_ret[k].size() == 2 || (m_ret[k].size() >= 1 && c_stop[k])) r = 1;
    return r;
  endfunction

  task automatic check_outputs();
    logic [NCH-1:0] cv;
    check("s_valid", 64'(s_valid), 64'(m_sv));
    if (m_sv) check("s_data", 64'(s_data), 64'(m_sd));
    check("o_inflight", 64'(o_inflight), 64'(m_tag.size()));
    check("o_err", 64'(o_err), 64'(m_err));
    check("o_stop", 64'(o_stop), 64'(exp_stop()));
    check("r_stop", 64'(r_stop), 64'(exp_rstop()));
    for (int k = 0; k < NCH; k++) cv[k] = (m_ret[k].size() != 0);
    check("c_valid", 64'(c_valid), 64'(cv));
    for (int k = 0; k < NCH; k++)
      if (cv[k]) check($sformatf("c_data%0d", k), 64'(c_data[k*DW +: DW]), 64'(m_ret[k][0]));
  endtask

  // One clock of the reference behaviour, evaluated from the pre-edge state.
  task automatic model_update();
    int g = -1;
    int pre_tag = m_tag.size();
    bit cpop [NCH];
    for (int k = 0; k < NCH; k++) cpop[k] = (m_ret[k].size() > 0) && !c_stop[k];
    if (!s_stop && pre_tag < TDEPTH)
      for (int i = 0; i < NCH; i++)
        if (g < 0 && m_in[(m_rr + i) % NCH].size() > 0) g = (m_rr + i) % NCH;
    for (int k = 0; k < NCH; k++) if (cpop[k]) void'(m_ret[k].pop_front());
    if (r_valid) begin
      if (pre_tag == 0) m_err = 1;
      else begin
        int ch = m_tag.pop_front();
        if (m_ret[ch].size() == 2) m_err = 1;
        else m_ret[ch].push_back(r_data);
      end
    end
    if (g >= 0) begin
      m_sd = m_in[g].pop_front();
      m_sv = 1;
      m_tag.push_back(g);
      m_rr = (g + 1) % NCH;
    end else m_sv = 0;
    for (int k = 0; k < NCH; k++)
      if (i_valid[k]) begin
        if (m_in[k].size() == 2) m_err = 1;
        else m_in[k].push_back(i_data[k*DW +: DW]);
      end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NCH; k++) i_data[k*DW +: DW] = DW'($urandom);
    r_data = DW'($urandom);
  endtask

  task automatic drain();
    i_valid = '0;
    for (int n = 0; n < 80; n++) begin
      bit busy = m_sv || (m_tag.size() != 0);
      for (int k = 0; k < NCH; k++) if (m_in[k].size() || m_ret[k].size()) busy = 1;
      if (!busy) break;
      c_stop  = '0;
      rand_data();
      r_valid = (m_tag.size() > 0) && !exp_rstop();
      step();
    end
    r_valid = 1'b0;
    check("drained", 64'(o_inflight), 64'd0);
  endtask

  initial begin
    logic [NCH-1:0] st;
    i_data = '0; i_valid = '0; s_stop = 1'b0; r_data = '0; r_valid = 1'b0; c_stop = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("s_data_rst", 64'(s_data), 64'd0);
    reset = 1'b0;

    // all four channels at once: issued 0,1,2,3
    for (int k = 0; k < NCH; k++) i_data[k*DW +: DW] = DW'(32'h100 + k);
    i_valid = '1;
    step();
    i_valid = '0;
    repeat (5) step();
    check("inflight4", 64'(o_inflight), 64'd4);

    // returns 0xA..0xD come back to channels 0..3
    for (int i = 0; i < 4; i++) begin
      r_valid = 1'b1;
      r_data  = DW'(32'hA + i);
      step();
    end
    r_valid = 1'b0;
    repeat (3) step();
    check("inflight0", 64'(o_inflight), 64'd0);

    // channel 2 streaming against a stalled shell
    s_stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st = exp_stop();
      rand_data();
      i_valid = st[2] ? 4'b0000 : 4'b0100;
      step();
    end
    check("stop2_held", 64'(o_stop[2]), 64'd1);
    check("err_stall", 64'(o_err), 64'd0);
    s_stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      st = exp_stop();
      rand_data();
      i_valid = st[2] ? 4'b0000 : 4'b0100;
      step();
    end
    drain();

    // fill tag FIFO, then a single return releases a single issue
    for (int i = 0; i < 16; i++) begin
      st = exp_stop();
      rand_data();
      i_valid = ~st;
      step();
    end
    i_valid = '0;
    check("inflight8", 64'(o_inflight), 64'd8);
    check("issue_blocked", 64'(s_valid), 64'd0);
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    repeat (3) step();
    check("inflight8_again", 64'(o_inflight), 64'd8);
    drain();

    // consumer 1 stalled while two of its returns land
    c_stop = 4'b0010;
    for (int i = 0; i < 20 && m_tag.size() < 3; i++) begin
      st = exp_stop();
      rand_data();
      i_valid = st[1] ? 4'b0000 : 4'b0010;
      step();
    end
    i_valid = '0;
    for (int i = 0; i < 2; i++) begin
      rand_data();
      r_valid = 1'b1;
      step();
    end
    r_valid = 1'b0;
    check("rstop_full", 64'(r_stop), 64'd1);
    check("cvalid1_held", 64'(c_valid[1]), 64'd1);
    repeat (2) step();
    c_stop = '0;
    drain();

    // randomized traffic with a well-behaved environment
    for (int i = 0; i < 400; i++) begin
      st = exp_stop();
      rand_data();
      for (int k = 0; k < NCH; k++)
        i_valid[k] = (!st[k] || (m_in[k].size() == 1 && $urandom_range(9) == 0))
                     && ($urandom_range(1) == 1);
      s_stop  = ($urandom_range(3) == 0);
      c_stop  = NCH'($urandom) & NCH'($urandom);
      r_valid = (m_tag.size() > 0) && !exp_rstop() && ($urandom_range(2) != 0);
      step();
    end
    s_stop = 1'b0;
    drain();
    check("err_clean", 64'(o_err), 64'd0);

    // stray return with nothing in flight
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    repeat (3) step();
    check("err_sticky", 64'(o_err), 64'd1);

    // reset in the middle of traffic
    for (int i = 0; i < 5; i++) begin
      st = exp_stop();
      rand_data();
      i_valid = ~st;
      r_valid = (m_tag.size() > 0) && ($urandom_range(1) == 1);
      step();
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    i_valid = '0; r_valid = 1'b0;
    m_reset();
    check_outputs();
    check("s_data_rst2", 64'(s_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      st = exp_stop();
      rand_data();
      i_valid = ~st;
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
